multicycle_control_fsm: RTL and testbench

- Control state machine for the multicycle RV32I core.
- Sits directly upstream of the ALU: each cycle it drives alu_op and the ALU operand selects.
- Consumes alu_bcond to resolve branches and the ecall halt check.
- Sequences IF/ID/EX/MEM/WB, drives datapath write enables, and stalls on a memory-ready handshake.

---
 rtl/multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RV32I core: sequences IF/ID/EX/MEM/WB/HALT and
// drives the ALU op, operand selects and datapath write enables each cycle.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       is_halted
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_BNE = 4'd8;
    localparam logic [3:0] OP_BLT = 4'd9;
    localparam logic [3:0] OP_BGE = 4'd10;
    localparam logic [3:0] OP_ECA = 4'd11;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_REG    = 2'd2;
    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;
    localparam logic [1:0] WB_ALU       = 2'd0;
    localparam logic [1:0] WB_ALUOUT    = 2'd1;
    localparam logic [1:0] WB_MDR       = 2'd2;

    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_ECALL, CL_NONE
    } iclass_t;

    state_t  state_reg;
    state_t  state_next;
    iclass_t iclass;
    logic [3:0] arith_op;
    logic [3:0] branch_op;
    logic       branch_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IF;
        else
            state_reg <= state_next;
    end

    always_comb begin
        iclass = CL_NONE;
        case (opcode)
            OPC_R:      iclass = CL_R;
            OPC_I:      iclass = CL_I;
            OPC_LOAD:   iclass = CL_LOAD;
            OPC_STORE:  iclass = CL_STORE;
            OPC_BRANCH: iclass = CL_BRANCH;
            OPC_JAL:    iclass = CL_JAL;
            OPC_JALR:   iclass = CL_JALR;
            OPC_ECALL:  iclass = CL_ECALL;
            default:    iclass = CL_NONE;
        endcase
    end

    // funct7_5 selects SUB only for register-register ops; SRAI/SRA fall back to SRL.
    always_comb begin
        arith_op = OP_ADD;
        case (funct3)
            3'b000:  arith_op = (iclass == CL_R && funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  arith_op = OP_SLL;
            3'b100:  arith_op = OP_XOR;
            3'b101:  arith_op = OP_SRL;
            3'b110:  arith_op = OP_OR;
            3'b111:  arith_op = OP_AND;
            default: arith_op = OP_ADD;
        endcase
    end

    // Unsupported branch kinds never redirect the PC, whatever alu_bcond says.
    always_comb begin
        branch_op    = OP_ADD;
        branch_valid = 1'b1;
        case (funct3)
            3'b000:  branch_op = OP_BEQ;
            3'b001:  branch_op = OP_BNE;
            3'b100:  branch_op = OP_BLT;
            3'b101:  branch_op = OP_BGE;
            default: branch_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        alu_op     = OP_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        is_halted  = 1'b0;

        case (state_reg)
            ST_IF: begin
                mem_read  = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_ID;
                end
            end

            ST_ID: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_IMM;
                state_next = (iclass == CL_NONE) ? ST_IF : ST_EX;
            end

            ST_EX: begin
                state_next = ST_IF;
                case (iclass)
                    CL_R: begin
                        alu_src_a  = SRC_A_REG;
                        alu_src_b  = SRC_B_REG;
                        alu_op     = arith_op;
                        state_next = ST_WB;
                    end
                    CL_I: begin
                        alu_src_a  = SRC_A_REG;
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = arith_op;
                        state_next = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_a  = SRC_A_REG;
                        alu_src_b  = SRC_B_IMM;
                        state_next = ST_MEM;
                    end
                    CL_BRANCH: begin
                        alu_src_a = SRC_A_REG;
                        alu_src_b = SRC_B_REG;
                        alu_op    = branch_op;
                        if (alu_bcond && branch_valid) begin
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                        end
                    end
                    CL_JAL: begin
                        alu_src_a = SRC_A_OLD_PC;
                        alu_src_b = SRC_B_FOUR;
                        reg_write = 1'b1;
                        wb_sel    = WB_ALU;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                    end
                    CL_JALR: begin
                        alu_src_a  = SRC_A_OLD_PC;
                        alu_src_b  = SRC_B_FOUR;
                        state_next = ST_WB;
                    end
                    CL_ECALL: begin
                        alu_src_a  = SRC_A_REG;
                        alu_op     = OP_ECA;
                        state_next = alu_bcond ? ST_HALT : ST_IF;
                    end
                    default: state_next = ST_IF;
                endcase
            end

            ST_MEM: begin
                i_or_d     = 1'b1;
                state_next = ST_IF;
                if (iclass == CL_LOAD) begin
                    mem_read   = 1'b1;
                    state_next = mem_ready ? ST_WB : ST_MEM;
                end else if (iclass == CL_STORE) begin
                    mem_write  = 1'b1;
                    state_next = mem_ready ? ST_IF : ST_MEM;
                end
            end

            ST_WB: begin
                state_next = ST_IF;
                case (iclass)
                    CL_R, CL_I: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_ALUOUT;
                    end
                    CL_LOAD: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_MDR;
                    end
                    CL_JALR: begin
                        // Link value already sits in ALUOut; the ALU computes the jump target.
                        reg_write = 1'b1;
                        wb_sel    = WB_ALUOUT;
                        alu_src_a = SRC_A_REG;
                        alu_src_b = SRC_B_IMM;
                        pc_write  = 1'b1;
                        pc_source = 1'b0;
                    end
                    default: ;
                endcase
            end

            ST_HALT: begin
                is_halted  = 1'b1;
                state_next = ST_HALT;
            end

            default: state_next = ST_IF;
        endcase

        // Reset is asynchronous, so the enables must drop combinationally too.
        if (!reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            is_halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction expected cycle traces
// are built from the instruction-class rules and compared cycle by cycle.
module tb_multicycle_control_fsm;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_BNE = 4'd8;
    localparam logic [3:0] OP_BLT = 4'd9;
    localparam logic [3:0] OP_BGE = 4'd10;
    localparam logic [3:0] OP_ECA = 4'd11;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [3:0] aop;
        logic [1:0] a;
        logic [1:0] b;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       rw;
        logic [1:0] wbs;
        logic       halt;
    } out_t;

    typedef struct {
        logic rdy;
        logic bc;
        out_t exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_bcond;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       is_halted;

    out_t obs;
    cyc_t trace[$];
    int   tests = 0;
    int   errors = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_bcond (alu_bcond),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .i_or_d    (i_or_d),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .is_halted (is_halted)
    );

    assign obs = '{alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
                   pc_write, pc_source, reg_write, wb_sel, is_halted};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic out_t base(input logic [3:0] aop, input logic [1:0] a, input logic [1:0] b);
        out_t o;
        o = '0;
        o.aop = aop;
        o.a = a;
        o.b = b;
        return o;
    endfunction

    function automatic out_t if_wait();
        out_t o;
        o = base(OP_ADD, 2'd0, 2'd2);
        o.mr = 1'b1;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic rdy, input logic bc, input out_t e);
        cyc_t c;
        c.rdy = rdy;
        c.bc = bc;
        c.exp = e;
        trace.push_back(c);
    endfunction

    function automatic logic [3:0] arith_ref(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? OP_SUB : OP_ADD;
            3'd1:    return OP_SLL;
            3'd4:    return OP_XOR;
            3'd5:    return OP_SRL;
            3'd6:    return OP_OR;
            3'd7:    return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    // Expected per-cycle trace of one instruction, from fetch to its last cycle.
    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                  input logic bc, input int ifw, input int memw);
        out_t e;
        logic taken;
        trace.delete();
        for (int i = 0; i < ifw; i++) push(1'b0, rbit(), if_wait());
        e = if_wait();
        e.irw = 1'b1;
        e.pcw = 1'b1;
        push(1'b1, rbit(), e);
        push(rbit(), rbit(), base(OP_ADD, 2'd1, 2'd1));
        case (op)
            OPC_R, OPC_I: begin
                push(rbit(), rbit(), base(arith_ref(f3, (op == OPC_R) && f75), 2'd2,
                                          (op == OPC_R) ? 2'd0 : 2'd1));
                e = base(OP_ADD, 2'd0, 2'd0);
                e.rw = 1'b1;
                e.wbs = 2'd1;
                push(rbit(), rbit(), e);
            end
            OPC_LOAD, OPC_STORE: begin
                push(rbit(), rbit(), base(OP_ADD, 2'd2, 2'd1));
                e = base(OP_ADD, 2'd0, 2'd0);
                e.iod = 1'b1;
                if (op == OPC_LOAD) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < memw; i++) push(1'b0, rbit(), e);
                push(1'b1, rbit(), e);
                if (op == OPC_LOAD) begin
                    e = base(OP_ADD, 2'd0, 2'd0);
                    e.rw = 1'b1;
                    e.wbs = 2'd2;
                    push(rbit(), rbit(), e);
                end
            end
            OPC_BRANCH: begin
                case (f3)
                    3'd0: e = base(OP_BEQ, 2'd2, 2'd0);
                    3'd1: e = base(OP_BNE, 2'd2, 2'd0);
                    3'd4: e = base(OP_BLT, 2'd2, 2'd0);
                    3'd5: e = base(OP_BGE, 2'd2, 2'd0);
                    default: e = base(OP_ADD, 2'd2, 2'd0);
                endcase
                taken = bc && (e.aop != OP_ADD);
                e.pcw = taken;
                e.pcs = taken;
                push(rbit(), bc, e);
            end
            OPC_JAL: begin
                e = base(OP_ADD, 2'd1, 2'd2);
                e.rw = 1'b1;
                e.pcw = 1'b1;
                e.pcs = 1'b1;
                push(rbit(), rbit(), e);
            end
            OPC_JALR: begin
                push(rbit(), rbit(), base(OP_ADD, 2'd1, 2'd2));
                e = base(OP_ADD, 2'd2, 2'd1);
                e.rw = 1'b1;
                e.wbs = 2'd1;
                e.pcw = 1'b1;
                push(rbit(), rbit(), e);
            end
            OPC_ECALL: push(rbit(), bc, base(OP_ECA, 2'd2, 2'd0));
            default: ;
        endcase
    endfunction

    task automatic run_trace(input int n);
        for (int k = 0; k < n && k < trace.size(); k++) begin
            @(negedge clk);
            opcode = cur_op;
            funct3 = cur_f3;
            funct7_5 = cur_f7;
            mem_ready = trace[k].rdy;
            alu_bcond = trace[k].bc;
            #1;
            check_eq($sformatf("op%b_f%0d_c%0d", cur_op, cur_f3, k), 32'(obs), 32'(trace[k].exp));
        end
    endtask

    task automatic do_reset();
        out_t en_mask;
        en_mask = '0;
        en_mask.mr = 1'b1;
        en_mask.mw = 1'b1;
        en_mask.irw = 1'b1;
        en_mask.pcw = 1'b1;
        en_mask.rw = 1'b1;
        en_mask.halt = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        alu_bcond = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_enables", 32'(obs & en_mask), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_release_if", 32'(obs), 32'(if_wait()));
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic bc, input int ifw, input int memw);
        cur_op = op;
        cur_f3 = f3;
        cur_f7 = f75;
        build(op, f3, f75, bc, ifw, memw);
        $display("[TB] op=%b f3=%0d f7=%0d bc=%0d ifw=%0d memw=%0d cycles=%0d",
                 op, f3, f75, bc, ifw, memw, trace.size());
        run_trace(trace.size());
        if (op == OPC_ECALL && bc) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                mem_ready = rbit();
                alu_bcond = rbit();
                #1;
                check_eq($sformatf("halt_c%0d", i), 32'(obs), 32'(base(OP_ADD, 2'd0, 2'd0) | out_t'(1)));
            end
            do_reset();
        end
    endtask

    initial begin
        logic [6:0] op;
        int sel;
        reset = 1'b0;
        mem_ready = 1'b0;
        alu_bcond = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;
        funct7_5 = 1'b0;
        cur_op = 7'd0;
        cur_f3 = 3'd0;
        cur_f7 = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset dropped mid-store while the write request is held.
        cur_op = OPC_STORE;
        cur_f3 = 3'd2;
        cur_f7 = 1'b0;
        build(OPC_STORE, 3'd2, 1'b0, 1'b0, 0, 3);
        $display("[TB] store interrupted by reset in MEM");
        run_trace(5);
        do_reset();

        run_instr(OPC_R, 3'd0, 1'b1, 1'b0, 3, 0);
        run_instr(OPC_R, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(OPC_BRANCH, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr(OPC_BRANCH, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr(OPC_BRANCH, 3'd6, 1'b0, 1'b1, 0, 0);
        run_instr(OPC_LOAD, 3'd2, 1'b0, 1'b0, 0, 2);
        run_instr(OPC_ECALL, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(OPC_ECALL, 3'd0, 1'b0, 1'b1, 0, 0);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 9: op = OPC_R;
                1: op = OPC_I;
                2: op = OPC_LOAD;
                3: op = OPC_STORE;
                4: op = OPC_BRANCH;
                5: op = OPC_JAL;
                6: op = OPC_JALR;
                7: op = OPC_ECALL;
                default: op = ($urandom_range(0, 1) == 0) ? OPC_LUI : 7'd0;
            endcase
            run_instr(op, 3'($urandom_range(0, 7)), rbit(),
                      (op == OPC_ECALL) ? ($urandom_range(0, 3) == 0) : rbit(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_eq("final_if", 32'(obs), 32'(if_wait()));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
